// File: rtl/mem_arbiter_if.sv
// Bundle of fetch port, load/store port and shared single-port memory signals.
// slave: arbiter view; master: requesters and memory view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  logic                  if_req;
  logic [31:0]           if_addr;
  logic                  if_kill;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [31:0]           if_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [31:0]           d_addr;
  logic [31:0]           d_wdata;
  logic [3:0]            d_be;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [31:0]           d_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [3:0]            mem_be;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [31:0]           mem_rdata;

  modport slave (
    input  if_req, if_addr, if_kill,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_be,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_kill,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_be,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for one shared single-port synchronous RAM.
// Data wins conflicts unless fetch has been denied STARVE_LIMIT cycles in a row.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mem_arbiter_if.slave         bus_io,
  output logic [CNT_WIDTH-1:0] conflict_cnt_o
);

  localparam int unsigned StarveW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic [StarveW-1:0]   starve_q, starve_d;
  logic [CNT_WIDTH-1:0] conflict_q, conflict_d;
  logic                 rsp_if_q, rsp_if_d;
  logic                 rsp_d_q, rsp_d_d;
  logic                 fetch_wins;
  logic                 if_gnt, d_gnt;

  // Only the word-address bits reach the RAM.
  logic unused_addr;
  assign unused_addr = ^{bus_io.if_addr, bus_io.d_addr};

  always_comb begin
    fetch_wins = (starve_q == StarveMax);
    if_gnt     = rst_ni & bus_io.if_req & (~bus_io.d_req | fetch_wins);
    d_gnt      = rst_ni & bus_io.d_req & ~(bus_io.if_req & fetch_wins);
  end

  always_comb begin
    bus_io.if_gnt    = if_gnt;
    bus_io.d_gnt     = d_gnt;
    bus_io.mem_en    = 1'b0;
    bus_io.mem_we    = 1'b0;
    bus_io.mem_be    = 4'b0000;
    bus_io.mem_addr  = '0;
    bus_io.mem_wdata = '0;
    if (if_gnt) begin
      bus_io.mem_en   = 1'b1;
      bus_io.mem_be   = 4'b1111;
      bus_io.mem_addr = bus_io.if_addr[ADDR_WIDTH+1:2];
    end else if (d_gnt) begin
      bus_io.mem_en    = 1'b1;
      bus_io.mem_we    = bus_io.d_we;
      bus_io.mem_be    = bus_io.d_we ? bus_io.d_be : 4'b1111;
      bus_io.mem_addr  = bus_io.d_addr[ADDR_WIDTH+1:2];
      bus_io.mem_wdata = bus_io.d_wdata;
    end
  end

  always_comb begin
    rsp_if_d = if_gnt;
    rsp_d_d  = d_gnt & ~bus_io.d_we;

    starve_d = '0;
    if (bus_io.if_req && !if_gnt) begin
      starve_d = (starve_q == StarveMax) ? starve_q : starve_q + 1'b1;
    end

    conflict_d = conflict_q;
    if (bus_io.if_req && bus_io.d_req && (conflict_q != {CNT_WIDTH{1'b1}})) begin
      conflict_d = conflict_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q   <= '0;
      conflict_q <= '0;
      rsp_if_q   <= 1'b0;
      rsp_d_q    <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      conflict_q <= conflict_d;
      rsp_if_q   <= rsp_if_d;
      rsp_d_q    <= rsp_d_d;
    end
  end

  // Kill only masks the fetch response; it never affects grants or data responses.
  always_comb begin
    bus_io.if_rvalid = rst_ni & rsp_if_q & ~bus_io.if_kill;
    bus_io.d_rvalid  = rst_ni & rsp_d_q;
    bus_io.if_rdata  = bus_io.mem_rdata;
    bus_io.d_rdata   = bus_io.mem_rdata;
  end

  assign conflict_cnt_o = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small synchronous RAM model.
module tb_mem_arbiter;
  localparam int unsigned AW = 10;

  logic       clk;
  logic       rst_n;
  logic [3:0] conflict_cnt;
  int         n_tests;
  int         n_fail;
  logic [31:0] mem [1024];

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus ();

  mem_arbiter #(
    .ADDR_WIDTH  (AW),
    .STARVE_LIMIT(4),
    .CNT_WIDTH   (4)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .bus_io        (bus),
    .conflict_cnt_o(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (bus.mem_be[b]) mem[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
        end
      end else begin
        bus.mem_rdata <= mem[bus.mem_addr];
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA500_0000 | i;
    rst_n        = 1'b0;
    bus.if_req   = 1'b1;
    bus.if_addr  = 32'h0;
    bus.if_kill  = 1'b0;
    bus.d_req    = 1'b1;
    bus.d_we     = 1'b0;
    bus.d_addr   = 32'h0;
    bus.d_wdata  = 32'h0;
    bus.d_be     = 4'h0;

    // Reset holds everything quiet even with requests pending
    repeat (2) @(negedge clk);
    check_eq("rst_if_gnt", bus.if_gnt, 0);
    check_eq("rst_d_gnt", bus.d_gnt, 0);
    check_eq("rst_mem_en", bus.mem_en, 0);
    check_eq("rst_conflict", conflict_cnt, 0);
    next_cycle();
    rst_n      = 1'b1;
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;

    // Fetch only: word 4
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("fetch_gnt", bus.if_gnt, 1);
      check_eq("fetch_mem_addr", bus.mem_addr, 4);
      check_eq("fetch_mem_we", bus.mem_we, 0);
      check_eq("fetch_mem_be", bus.mem_be, 4'hF);
      check_eq("fetch_rvalid", bus.if_rvalid, (c > 0));
      if (c > 0) check_eq("fetch_rdata", bus.if_rdata, 32'hA500_0004);
      next_cycle();
    end
    bus.if_req = 1'b0;
    @(negedge clk);
    check_eq("fetch_idle_gnt", bus.if_gnt, 0);
    check_eq("fetch_idle_en", bus.mem_en, 0);
    check_eq("fetch_last_rvalid", bus.if_rvalid, 1);
    check_eq("fetch_last_rdata", bus.if_rdata, 32'hA500_0004);
    next_cycle();
    @(negedge clk);
    check_eq("fetch_done_rvalid", bus.if_rvalid, 0);

    // Store 0xDEADBEEF to 0x20, then load it back
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h20;
    bus.d_wdata = 32'hDEAD_BEEF;
    bus.d_be    = 4'hF;
    @(negedge clk);
    check_eq("st_gnt", bus.d_gnt, 1);
    check_eq("st_mem_we", bus.mem_we, 1);
    check_eq("st_mem_addr", bus.mem_addr, 8);
    check_eq("st_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    bus.d_we = 1'b0;
    bus.d_be = 4'h1;
    @(negedge clk);
    check_eq("ld_gnt", bus.d_gnt, 1);
    check_eq("st_no_rvalid", bus.d_rvalid, 0);
    check_eq("ld_mem_be", bus.mem_be, 4'hF);
    check_eq("ld_mem_we", bus.mem_we, 0);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check_eq("ld_rvalid", bus.d_rvalid, 1);
    check_eq("ld_rdata", bus.d_rdata, 32'hDEAD_BEEF);

    // Partial store into word 9 (0xA5000009), then load
    next_cycle();
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h24;
    bus.d_wdata = 32'h1122_3344;
    bus.d_be    = 4'b0011;
    @(negedge clk);
    check_eq("pst_mem_be", bus.mem_be, 4'b0011);
    next_cycle();
    bus.d_we = 1'b0;
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check_eq("pld_rvalid", bus.d_rvalid, 1);
    check_eq("pld_rdata", bus.d_rdata, 32'hA500_3344);

    // Continuous conflict: D,D,D,D,I pattern, counter saturates at 15
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h40;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h80;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_eq("cf_if_gnt", bus.if_gnt, (k % 5 == 4));
      check_eq("cf_d_gnt", bus.d_gnt, (k % 5 != 4));
      check_eq("cf_cnt", conflict_cnt, (k < 15) ? k : 15);
      next_cycle();
    end
    bus.if_req = 1'b0;
    bus.d_req  = 1'b0;
    @(negedge clk);
    check_eq("cf_cnt_hold", conflict_cnt, 15);
    check_eq("cf_last_if_rvalid", bus.if_rvalid, 1);
    check_eq("cf_last_d_rvalid", bus.d_rvalid, 0);

    // Kill: masks fetch response, leaves grants and load response alone
    next_cycle();
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h10;
    @(negedge clk);
    check_eq("kill_fetch_gnt", bus.if_gnt, 1);
    next_cycle();
    bus.if_req  = 1'b0;
    bus.if_kill = 1'b1;
    bus.d_req   = 1'b1;
    bus.d_addr  = 32'h20;
    @(negedge clk);
    check_eq("kill_if_rvalid", bus.if_rvalid, 0);
    check_eq("kill_d_gnt", bus.d_gnt, 1);
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clk);
    check_eq("kill_d_rvalid", bus.d_rvalid, 1);
    check_eq("kill_d_rdata", bus.d_rdata, 32'hDEAD_BEEF);
    next_cycle();
    bus.if_kill = 1'b0;

    // Reset while a load response is in flight
    bus.d_req  = 1'b1;
    bus.d_addr = 32'h24;
    bus.if_req = 1'b1;
    @(negedge clk);
    check_eq("rf_d_gnt", bus.d_gnt, 1);
    check_eq("rf_if_gnt", bus.if_gnt, 0);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rf_d_rvalid", bus.d_rvalid, 0);
    check_eq("rf_mem_en", bus.mem_en, 0);
    check_eq("rf_d_gnt_rst", bus.d_gnt, 0);
    check_eq("rf_cnt", conflict_cnt, 0);
    @(negedge clk);
    check_eq("rf_d_rvalid2", bus.d_rvalid, 0);
    check_eq("rf_cnt2", conflict_cnt, 0);
    next_cycle();
    rst_n      = 1'b1;
    bus.d_req  = 1'b0;
    bus.if_req = 1'b0;
    @(negedge clk);
    check_eq("rf_d_rvalid3", bus.d_rvalid, 0);
    next_cycle();
    bus.if_req = 1'b1;
    @(negedge clk);
    check_eq("post_rst_gnt", bus.if_gnt, 1);
    next_cycle();
    bus.if_req = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
